// File: rtl/mem_arbiter_if.sv
// Bundle of fetch/data request ports and the shared memory port served by mem_arbiter.
// master: requesters plus memory model; slave: the arbiter.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic        busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wr_data, mem_wr_ena, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wr_data, mem_wr_ena, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch I, data D) arbiter onto a single memory port with IDLE/ACCESS/RESP sequencing.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed D priority.
module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] CNT_RELOAD = 2'(RD_LAT - 1);

  state_t     state_r;
  logic [1:0] cnt_r;
  logic       sel_d_r;
  logic       we_r;

  logic       cand_i_s;
  logic       cand_d_s;
  logic       arb_s;
  logic       grant_s;
  logic       pick_d_s;

`ifdef MEM_ARB_RR_EN
  logic       last_d_r;
`endif

  // Arbitration window and winner selection
  always_comb begin
    cand_i_s = bus.i_req;
    cand_d_s = bus.d_req;
    arb_s    = 1'b0;
    case (state_r)
      IDLE, RESP: begin
        arb_s = 1'b1;
      end
      ACCESS: begin
        // A write ends after one cycle; its own requester still shows the
        // request it is being granted for, so only the other port may win.
        if (we_r) begin
          arb_s = 1'b1;
          if (sel_d_r) begin
            cand_d_s = 1'b0;
          end else begin
            cand_i_s = 1'b0;
          end
        end else begin
          arb_s = 1'b0;
        end
      end
      default: begin
        arb_s = 1'b0;
      end
    endcase
    grant_s = arb_s & (cand_i_s | cand_d_s);
`ifdef MEM_ARB_RR_EN
    if (cand_i_s && cand_d_s) begin
      pick_d_s = ~last_d_r;
    end else begin
      pick_d_s = cand_d_s;
    end
`else
    pick_d_s = cand_d_s;
`endif
  end

  // Sequencer state, latched request fields and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      cnt_r           <= 2'd0;
      sel_d_r         <= 1'b0;
      we_r            <= 1'b0;
      bus.i_gnt       <= 1'b0;
      bus.d_gnt       <= 1'b0;
      bus.i_rvalid    <= 1'b0;
      bus.d_rvalid    <= 1'b0;
      bus.i_rdata     <= 32'd0;
      bus.d_rdata     <= 32'd0;
      bus.mem_addr    <= 32'd0;
      bus.mem_wr_data <= 32'd0;
      bus.mem_wr_ena  <= 1'b0;
      bus.busy        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_r        <= 1'b0;
`endif
    end else begin
      bus.i_gnt      <= 1'b0;
      bus.d_gnt      <= 1'b0;
      bus.i_rvalid   <= 1'b0;
      bus.d_rvalid   <= 1'b0;
      bus.mem_wr_ena <= 1'b0;
      if (grant_s) begin
        state_r  <= ACCESS;
        bus.busy <= 1'b1;
        cnt_r    <= CNT_RELOAD;
        sel_d_r  <= pick_d_s;
`ifdef MEM_ARB_RR_EN
        last_d_r <= pick_d_s;
`endif
        if (pick_d_s) begin
          bus.d_gnt       <= 1'b1;
          bus.mem_addr    <= bus.d_addr;
          bus.mem_wr_data <= bus.d_wdata;
          bus.mem_wr_ena  <= bus.d_we;
          we_r            <= bus.d_we;
        end else begin
          bus.i_gnt    <= 1'b1;
          bus.mem_addr <= bus.i_addr;
          we_r         <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r  <= IDLE;
            bus.busy <= 1'b0;
          end
          ACCESS: begin
            if (we_r) begin
              state_r  <= IDLE;
              bus.busy <= 1'b0;
            end else if (cnt_r == 2'd0) begin
              state_r <= RESP;
              if (sel_d_r) begin
                bus.d_rdata  <= bus.mem_rd_data;
                bus.d_rvalid <= 1'b1;
              end else begin
                bus.i_rdata  <= bus.mem_rd_data;
                bus.i_rvalid <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r - 2'd1;
            end
          end
          RESP: begin
            state_r  <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued requesters and a memory model on an RD_LAT=1 instance,
// directed latency/reset checks on an RD_LAT=3 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  mem_arbiter_if bus1();
  mem_arbiter_if bus3();

  mem_arbiter #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  mem_arbiter #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        i_q[$];
  txn_t        d_q[$];
  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  logic [63:0] wr_exp[$];
  logic        glog[$];

  logic [31:0] tb_mem  [0:1023];
  logic [31:0] ref_mem [0:1023];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int i_pres_cyc = 0, d_pres_cyc = 0;
  int i_gnt_cyc = 0, d_gnt_cyc = 0;
  int i_rv_cyc = 0, d_rv_cyc = 0;
  int wr_cnt = 0;

  function automatic logic [31:0] init_word(input int k);
    if (k == 64) return 32'h8C08_0004;
    return 32'hA500_0000 ^ (32'(k) * 32'h0001_0001);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_i(input logic [31:0] addr);
    i_q.push_back('{we: 1'b0, addr: addr, wdata: 32'd0});
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    d_q.push_back('{we: we, addr: addr, wdata: wdata});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((i_q.size() != 0 || d_q.size() != 0 || bus1.i_req || bus1.d_req ||
            i_exp.size() != 0 || d_exp.size() != 0 || wr_exp.size() != 0 || bus1.busy)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_timeout: waited %0d cycles, pending i=%0d d=%0d", name, n,
               i_exp.size(), d_exp.size());
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  assign bus1.mem_rd_data = tb_mem[bus1.mem_addr[9:0]];
  assign bus3.mem_rd_data = {bus3.mem_addr[15:0], ~bus3.mem_addr[15:0]};

  // memory behind the RD_LAT=1 instance
  initial begin : mem_model
    for (int k = 0; k < 1024; k++) tb_mem[k] = init_word(k);
    forever begin
      @(posedge clk);
      if (bus1.mem_wr_ena) tb_mem[bus1.mem_addr[9:0]] <= bus1.mem_wr_data;
    end
  end

  initial begin : i_drv
    txn_t t;
    bus1.i_req  = 1'b0;
    bus1.i_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (!bus1.i_req || bus1.i_gnt) begin
        if (i_q.size() > 0) begin
          t = i_q.pop_front();
          bus1.i_req  = 1'b1;
          bus1.i_addr = t.addr;
          i_pres_cyc  = cyc;
          i_exp.push_back(ref_mem[t.addr[9:0]]);
        end else begin
          bus1.i_req = 1'b0;
        end
      end
    end
  end

  initial begin : d_drv
    txn_t t;
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
    bus1.d_req   = 1'b0;
    bus1.d_we    = 1'b0;
    bus1.d_addr  = 32'd0;
    bus1.d_wdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!bus1.d_req || bus1.d_gnt) begin
        if (d_q.size() > 0) begin
          t = d_q.pop_front();
          bus1.d_req   = 1'b1;
          bus1.d_we    = t.we;
          bus1.d_addr  = t.addr;
          bus1.d_wdata = t.wdata;
          d_pres_cyc   = cyc;
          if (t.we) begin
            ref_mem[t.addr[9:0]] = t.wdata;
            wr_exp.push_back({t.addr, t.wdata});
          end else begin
            d_exp.push_back(ref_mem[t.addr[9:0]]);
          end
        end else begin
          bus1.d_req = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (!rst1) begin
        if (bus1.i_gnt && bus1.d_gnt) begin
          total++; bad++;
          $display("FAIL dual_gnt: both grants high in cycle %0d", cyc);
        end
        if (bus1.i_gnt) begin i_gnt_cyc = cyc; glog.push_back(1'b0); end
        if (bus1.d_gnt) begin d_gnt_cyc = cyc; glog.push_back(1'b1); end
        if (bus1.i_rvalid && bus1.d_rvalid) begin
          total++; bad++;
          $display("FAIL dual_rvalid: both rvalid high in cycle %0d", cyc);
        end
        if (bus1.i_rvalid) begin
          i_rv_cyc = cyc;
          if (i_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL i_rvalid_extra: got rdata %h with nothing expected", bus1.i_rdata);
          end else check("i_rdata", bus1.i_rdata, i_exp.pop_front());
        end
        if (bus1.d_rvalid) begin
          d_rv_cyc = cyc;
          if (d_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL d_rvalid_extra: got rdata %h with nothing expected", bus1.d_rdata);
          end else check("d_rdata", bus1.d_rdata, d_exp.pop_front());
        end
        if (bus1.mem_wr_ena) begin
          wr_cnt++;
          if (wr_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_extra: strobe at addr %h with nothing expected", bus1.mem_addr);
          end else begin
            w = wr_exp.pop_front();
            check("wr_addr", bus1.mem_addr, w[63:32]);
            check("wr_data", bus1.mem_wr_data, w[31:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    logic ok;
    logic rv_seen;
    logic exp_d;
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus3.i_req = 1'b0; bus3.i_addr = 32'd0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = 32'd0; bus3.d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus1.busy, 32'd0);
    check("rst_gnt", {bus1.i_gnt, bus1.d_gnt}, 32'd0);
    check("rst_rvalid", {bus1.i_rvalid, bus1.d_rvalid}, 32'd0);
    check("rst_wr_ena", bus1.mem_wr_ena, 32'd0);
    check("rst_mem_addr", bus1.mem_addr, 32'd0);
    check("rst_rdata", bus1.i_rdata | bus1.d_rdata, 32'd0);
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // simultaneous held requests straight after reset
    @(posedge clk); #1;
    glog.delete();
    for (int k = 0; k < 8; k++) begin
      push_d(1'b0, 32'd32 + 32'(k), 32'd0);
      push_i(32'(k));
    end
    wait_idle("contend");
    check("contend_grants", 32'(glog.size()), 32'd16);
    if (glog.size() >= 8) begin
      for (int g = 0; g < 8; g++) begin
`ifdef MEM_ARB_RR_EN
        exp_d = (g % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        check($sformatf("grant_order_%0d", g), glog[g], exp_d);
      end
    end

    // fetch latency with RD_LAT=1
    @(posedge clk); #1;
    push_i(32'h0000_0040);
    wait_idle("fetch");
    check("fetch_gnt_lat", 32'(i_gnt_cyc - i_pres_cyc), 32'd1);
    check("fetch_rv_lat", 32'(i_rv_cyc - i_pres_cyc), 32'd2);
    check("fetch_word", bus1.i_rdata, 32'h8C08_0004);

    // write then readback on D
    @(posedge clk); #1;
    base = wr_cnt;
    push_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    push_d(1'b0, 32'h0000_0100, 32'd0);
    wait_idle("wr_rd");
    check("wr_strobes", 32'(wr_cnt - base), 32'd1);
    check("readback", bus1.d_rdata, 32'hDEAD_BEEF);

    // write immediately followed by a fetch of the same word
    @(posedge clk); #1;
    base = wr_cnt;
    push_d(1'b1, 32'h0000_0104, 32'h1234_5678);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk); #1;
      if (bus1.d_gnt) ok = 1'b1;
    end
    check("wf_d_gnt_seen", ok, 32'd1);
    push_i(32'h0000_0104);
    wait_idle("wr_fetch");
    check("wf_back_to_back", 32'(i_gnt_cyc - d_gnt_cyc), 32'd1);
    check("wf_strobes", 32'(wr_cnt - base), 32'd1);
    check("wf_fetch_word", bus1.i_rdata, 32'h1234_5678);

    // random mixed traffic; I reads a region D never writes
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) push_i(32'($urandom_range(0, 31)));
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1)
          push_d(1'b1, 32'd32 + 32'($urandom_range(0, 31)), $urandom());
        else
          push_d(1'b0, 32'd32 + 32'($urandom_range(0, 31)), 32'd0);
      end
    end
    wait_idle("random");

    // RD_LAT=3 read of 0x200
    @(negedge clk);
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h0000_0200;
    @(posedge clk); #1;
    check("l3_gnt", bus3.d_gnt, 32'd1);
    check("l3_addr_c1", bus3.mem_addr, 32'h0000_0200);
    bus3.d_req = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("l3_addr_c%0d", c), bus3.mem_addr, 32'h0000_0200);
      check($sformatf("l3_no_rv_c%0d", c), bus3.d_rvalid, 32'd0);
    end
    @(posedge clk); #1;
    check("l3_rvalid", bus3.d_rvalid, 32'd1);
    check("l3_rdata", bus3.d_rdata, 32'h0200_FDFF);
    @(posedge clk); #1;
    check("l3_rv_pulse", bus3.d_rvalid, 32'd0);
    check("l3_busy_done", bus3.busy, 32'd0);

    // reset in the second ACCESS cycle of an RD_LAT=3 fetch
    @(negedge clk);
    bus3.i_req = 1'b1; bus3.i_addr = 32'h0000_0300;
    @(posedge clk); #1;
    check("ab_gnt", bus3.i_gnt, 32'd1);
    bus3.i_req = 1'b0;
    @(posedge clk); #1;
    check("ab_busy_before", bus3.busy, 32'd1);
    rst3 = 1'b1;
    #1;
    check("ab_busy", bus3.busy, 32'd0);
    check("ab_addr", bus3.mem_addr, 32'd0);
    check("ab_wdata", bus3.mem_wr_data, 32'd0);
    check("ab_rdata", bus3.i_rdata | bus3.d_rdata, 32'd0);
    check("ab_flags", {bus3.i_gnt, bus3.d_gnt, bus3.i_rvalid, bus3.d_rvalid, bus3.mem_wr_ena},
          32'd0);
    rv_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus3.i_rvalid || bus3.d_rvalid) rv_seen = 1'b1;
    end
    check("ab_no_rvalid", rv_seen, 32'd0);
    rst3 = 1'b0;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h0000_0204;
    @(posedge clk); #1;
    check("post_rst_gnt", bus3.d_gnt, 32'd1);
    bus3.d_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    check("post_rst_rvalid", bus3.d_rvalid, 32'd1);
    check("post_rst_rdata", bus3.d_rdata, 32'h0204_FDFB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
